// File: rtl/cpu_clk_pkg.sv
// Shared encodings and clamp limits for the CPU clock controller.
package cpu_clk_pkg;

  typedef enum logic [1:0] {
    MODE_RUN   = 2'b00,
    MODE_STEP  = 2'b01,
    MODE_BURST = 2'b10,
    MODE_HOLD  = 2'b11
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_BURST,
    ST_HALTED
  } state_t;

  localparam int MIN_PERIOD = 2;
  localparam int MIN_DUTY   = 1;

endpackage

// File: rtl/btn_debounce.sv
// Button synchroniser + debounce; emits a one-cycle pulse on an accepted press.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic press
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]    sync_pipe;
  logic [CW-1:0] cnt;
  logic          level;
  logic          raw;

  assign raw = sync_pipe[1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_pipe <= '0;
      cnt       <= '0;
      level     <= 1'b0;
      press     <= 1'b0;
    end else begin
      sync_pipe <= {sync_pipe[0], btn};
      press     <= 1'b0;
      if (raw == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        // Nth consecutive differing sample: accept the new level
        level <= raw;
        cnt   <= '0;
        press <= raw;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/cpu_clock_ctrl.sv
// CPU clock generator: period/duty divider, step/burst/run modes, halt, tick counter.
module cpu_clock_ctrl
  import cpu_clk_pkg::*;
#(
  parameter int DIV_WIDTH       = 32,
  parameter int DEBOUNCE_CYCLES = 100_000,
  parameter int BURST_WIDTH     = 8,
  parameter int TCNT_WIDTH      = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [DIV_WIDTH-1:0]   period_i,
  input  logic [DIV_WIDTH-1:0]   duty_i,
  input  logic [1:0]             mode_i,
  input  logic                   step_btn_i,
  input  logic [BURST_WIDTH-1:0] burst_len_i,
  input  logic                   halt_i,
  output logic                   cpu_clk_o,
  output logic                   cpu_tick_o,
  output logic                   busy_o,
  output logic [TCNT_WIDTH-1:0]  tick_count_o
);

  state_t                 state, state_n;
  mode_t                  mode;
  logic                   press;
  logic [DIV_WIDTH-1:0]   phase, per_q, duty_q, eff_per, eff_duty;
  logic                   active, period_end, boundary;
  logic                   start, burst_load, burst_dec;
  logic [BURST_WIDTH-1:0] burst_rem;

  assign mode = mode_t'(mode_i);

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (step_btn_i),
    .press (press)
  );

  assign eff_per  = (period_i < DIV_WIDTH'(MIN_PERIOD)) ? DIV_WIDTH'(MIN_PERIOD) : period_i;
  assign eff_duty = (duty_i < DIV_WIDTH'(MIN_DUTY)) ? DIV_WIDTH'(MIN_DUTY) :
                    (duty_i >= eff_per)             ? eff_per - DIV_WIDTH'(1) : duty_i;

  // Decisions are only taken when no period is running or the last phase is reached
  assign period_end = active && (phase == per_q - DIV_WIDTH'(1));
  assign boundary   = !active || period_end;
  assign busy_o     = active;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    if (boundary) begin
      if (halt_i) state_n = ST_HALTED;
      else begin
        case (state)
          ST_IDLE: begin
            if (mode == MODE_RUN) state_n = ST_RUN;
            else if (mode == MODE_BURST && press && burst_len_i != '0) state_n = ST_BURST;
          end
          ST_RUN:    if (mode != MODE_RUN) state_n = ST_IDLE;
          ST_BURST:  if (burst_rem <= BURST_WIDTH'(1)) state_n = ST_IDLE;
          ST_HALTED: state_n = ST_IDLE;
          default:   state_n = ST_IDLE;
        endcase
      end
    end
  end

  always_comb begin
    start      = 1'b0;
    burst_load = 1'b0;
    burst_dec  = 1'b0;
    if (boundary && !halt_i) begin
      case (state)
        ST_IDLE: begin
          if (mode == MODE_RUN) start = 1'b1;
          else if (mode == MODE_STEP && press) start = 1'b1;
          else if (mode == MODE_BURST && press && burst_len_i != '0) begin
            start      = 1'b1;
            burst_load = 1'b1;
          end
        end
        ST_RUN: start = (mode == MODE_RUN);
        ST_BURST: begin
          burst_dec = 1'b1;
          start     = (burst_rem > BURST_WIDTH'(1));
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      burst_rem <= '0;
    end else if (burst_load) begin
      burst_rem <= burst_len_i;
    end else if (state_n != ST_BURST) begin
      burst_rem <= '0;
    end else if (burst_dec) begin
      burst_rem <= burst_rem - BURST_WIDTH'(1);
    end
  end

  // Period engine: P and D are latched at start so runtime changes never cut a phase short
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase        <= '0;
      per_q        <= DIV_WIDTH'(MIN_PERIOD);
      duty_q       <= DIV_WIDTH'(MIN_DUTY);
      active       <= 1'b0;
      cpu_clk_o    <= 1'b0;
      cpu_tick_o   <= 1'b0;
      tick_count_o <= '0;
    end else if (start) begin
      phase        <= '0;
      per_q        <= eff_per;
      duty_q       <= eff_duty;
      active       <= 1'b1;
      cpu_clk_o    <= 1'b1;
      cpu_tick_o   <= 1'b1;
      tick_count_o <= tick_count_o + TCNT_WIDTH'(1);
    end else if (active && !period_end) begin
      phase      <= phase + DIV_WIDTH'(1);
      cpu_clk_o  <= (phase + DIV_WIDTH'(1)) < duty_q;
      cpu_tick_o <= 1'b0;
    end else begin
      phase      <= '0;
      active     <= 1'b0;
      cpu_clk_o  <= 1'b0;
      cpu_tick_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_clock_ctrl.sv
// Directed bench for cpu_clock_ctrl with a short debounce window.
module tb_cpu_clock_ctrl;
  import cpu_clk_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] period_i = 32'd10;
  logic [31:0] duty_i = 32'd5;
  logic [1:0]  mode_i = MODE_HOLD;
  logic        step_btn_i = 1'b0;
  logic [7:0]  burst_len_i = 8'd0;
  logic        halt_i = 1'b0;
  logic        cpu_clk_o, cpu_tick_o, busy_o;
  logic [15:0] tick_count_o;

  int total = 0;
  int bad = 0;
  int tk, hi, t0, t1, t2, errs;
  logic found;
  logic [0:14] clk_exp, tick_exp;

  always #5 clk = ~clk;

  cpu_clock_ctrl #(
    .DIV_WIDTH(32), .DEBOUNCE_CYCLES(8), .BURST_WIDTH(8), .TCNT_WIDTH(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .period_i(period_i), .duty_i(duty_i),
    .mode_i(mode_i), .step_btn_i(step_btn_i), .burst_len_i(burst_len_i),
    .halt_i(halt_i), .cpu_clk_o(cpu_clk_o), .cpu_tick_o(cpu_tick_o),
    .busy_o(busy_o), .tick_count_o(tick_count_o)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // n negedge samples; button high when i<a or i>=b
  task automatic run(input int n, input int a, input int b,
                     output int ticks, output int highs,
                     output int f0, output int f1, output int f2);
    ticks = 0; highs = 0; f0 = -1; f1 = -1; f2 = -1;
    for (int i = 0; i < n; i++) begin
      step_btn_i = (i < a) || (i >= b);
      @(negedge clk);
      if (cpu_tick_o === 1'b1) begin
        if (ticks == 0) f0 = i;
        else if (ticks == 1) f1 = i;
        else if (ticks == 2) f2 = i;
        ticks++;
      end
      if (cpu_clk_o === 1'b1) highs++;
    end
  endtask

  initial begin
    // reset state
    #1;
    chk("rst_clk", cpu_clk_o, 0);
    chk("rst_tick", cpu_tick_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_count", tick_count_o, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // HOLD: no ticks
    run(5, 0, 5, tk, hi, t0, t1, t2);
    chk("hold_ticks", tk, 0);
    chk("hold_busy", busy_o, 0);

    // RUN 10/5
    mode_i = MODE_RUN;
    errs = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (cpu_clk_o !== ((i % 10) < 5)) errs++;
      if (cpu_tick_o !== ((i % 10) == 0)) errs++;
    end
    chk("run_pattern_errs", errs, 0);
    chk("run_count_30", tick_count_o, 3);
    mode_i = MODE_HOLD;
    run(8, 0, 8, tk, hi, t0, t1, t2);
    chk("run_stop_ticks", tk, 0);
    chk("run_stop_clk", cpu_clk_o, 0);

    // clamps and mid-period parameter change
    clk_exp  = 15'b111000101011101;
    tick_exp = 15'b100000101010001;
    period_i = 32'd6; duty_i = 32'd3; mode_i = MODE_RUN;
    errs = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (cpu_clk_o !== clk_exp[i]) errs++;
      if (cpu_tick_o !== tick_exp[i]) errs++;
      if (i == 2) begin period_i = 32'd0; duty_i = 32'd0; end
      if (i == 8) begin period_i = 32'd4; duty_i = 32'd7; end
      if (i == 14) mode_i = MODE_HOLD;
    end
    chk("clamp_pattern_errs", errs, 0);
    run(8, 0, 8, tk, hi, t0, t1, t2);
    chk("clamp_tail_ticks", tk, 0);
    chk("clamp_count", tick_count_o, 8);
    chk("clamp_busy_end", busy_o, 0);

    // STEP with a bouncing button
    period_i = 32'd4; duty_i = 32'd2; mode_i = MODE_STEP;
    for (int i = 0; i < 5; i++) begin
      step_btn_i = (i % 2 == 0);
      @(negedge clk);
    end
    run(40, 40, 40, tk, hi, t0, t1, t2);
    chk("step1_ticks", tk, 1);
    chk("step1_latency_ok", (t0 >= 6 && t0 <= 12), 1);
    run(40, 0, 20, tk, hi, t0, t1, t2);
    chk("step2_ticks", tk, 1);
    run(20, 0, 20, tk, hi, t0, t1, t2);
    chk("step_release_ticks", tk, 0);
    chk("step_count", tick_count_o, 10);

    // BURST of 3 at period 4
    mode_i = MODE_BURST; burst_len_i = 8'd3;
    run(40, 40, 40, tk, hi, t0, t1, t2);
    chk("burst_ticks", tk, 3);
    chk("burst_gap1", t1 - t0, 4);
    chk("burst_gap2", t2 - t1, 4);
    chk("burst_busy_end", busy_o, 0);
    run(20, 0, 20, tk, hi, t0, t1, t2);
    burst_len_i = 8'd0;
    run(30, 30, 30, tk, hi, t0, t1, t2);
    chk("burst_len0_ticks", tk, 0);
    run(20, 0, 20, tk, hi, t0, t1, t2);
    chk("burst_count", tick_count_o, 13);

    // press during a running burst is dropped
    burst_len_i = 8'd3; period_i = 32'd20; duty_i = 32'd10;
    run(110, 25, 45, tk, hi, t0, t1, t2);
    chk("burst_mid_ticks", tk, 3);
    chk("burst_mid_gap", t1 - t0, 20);
    run(20, 0, 20, tk, hi, t0, t1, t2);
    chk("burst_mid_release", tk, 0);
    chk("burst_mid_count", tick_count_o, 16);

    // halt raised at phase 2 of 8/4
    period_i = 32'd8; duty_i = 32'd4; mode_i = MODE_RUN;
    @(negedge clk);
    chk("halt_start_tick", cpu_tick_o, 1);
    chk("halt_start_count", tick_count_o, 17);
    repeat (2) @(negedge clk);
    halt_i = 1'b1;
    run(25, 0, 25, tk, hi, t0, t1, t2);
    chk("halt_ticks", tk, 0);
    chk("halt_highs", hi, 1);
    chk("halt_clk", cpu_clk_o, 0);
    chk("halt_busy", busy_o, 0);
    halt_i = 1'b0;
    run(30, 0, 30, tk, hi, t0, t1, t2);
    chk("unhalt_ticks", tk, 4);
    chk("unhalt_first", t0, 1);
    chk("unhalt_count", tick_count_o, 21);

    // reset mid-burst
    mode_i = MODE_BURST; burst_len_i = 8'd3; period_i = 32'd20; duty_i = 32'd10;
    step_btn_i = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (cpu_tick_o === 1'b1) found = 1'b1;
    end
    chk("rstb_burst_seen", found, 1);
    repeat (5) @(negedge clk);
    chk("rstb_busy_before", busy_o, 1);
    chk("rstb_count_before", tick_count_o, 22);
    step_btn_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rstb_clk", cpu_clk_o, 0);
    chk("rstb_busy", busy_o, 0);
    chk("rstb_count", tick_count_o, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    run(40, 0, 40, tk, hi, t0, t1, t2);
    chk("rstb_no_ticks", tk, 0);
    run(20, 20, 20, tk, hi, t0, t1, t2);
    chk("rstb_new_press_ticks", tk, 1);
    chk("rstb_new_count", tick_count_o, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
